// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding and the
// default bus timeout.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/mem_wb_buffer.sv
// MEM/WB pipeline register. A bubble clears the two control bits and keeps
// the data fields, so a frozen instruction never writes back twice.
module mem_wb_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble_i,
    input  logic        regwrite_i,
    input  logic        memtoreg_i,
    input  logic [31:0] read_data_i,
    input  logic [31:0] alu_result_i,
    input  logic [4:0]  write_reg_i,
    output logic        regwrite_o,
    output logic        memtoreg_o,
    output logic [31:0] read_data_o,
    output logic [31:0] alu_result_o,
    output logic [4:0]  write_reg_o
);

    logic        regwrite_q;
    logic        memtoreg_q;
    logic [31:0] read_data_q;
    logic [31:0] alu_result_q;
    logic [4:0]  write_reg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            read_data_q  <= 32'h0;
            alu_result_q <= 32'h0;
            write_reg_q  <= 5'h0;
        end else if (bubble_i) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            regwrite_q   <= regwrite_i;
            memtoreg_q   <= memtoreg_i;
            read_data_q  <= read_data_i;
            alu_result_q <= alu_result_i;
            write_reg_q  <= write_reg_i;
        end
    end

    assign regwrite_o   = regwrite_q;
    assign memtoreg_o   = memtoreg_q;
    assign read_data_o  = read_data_q;
    assign alu_result_o = alu_result_q;
    assign write_reg_o  = write_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory bus, stalls upstream while an access is
// in flight, resolves branches and feeds the MEM/WB register.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic        Zero_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_reg_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        PCSrc,
    output logic        mem_error,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_out,
    output state_t      state_dbg_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Bus handshake: mem_req rises on entry to ACCESS and holds addr/we/wdata
    // stable until the first edge that sees mem_ready=1 (or the timeout),
    // where it drops. mem_ready is ignored whenever mem_req is low.
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          abort_q, abort_d;
    logic          err_q, err_d;
    logic          stall_c;

    logic mem_op, aligned, access, misaligned_op, timeout_hit;

    assign mem_op        = MemRead_in | MemWrite_in;
    assign aligned       = (alu_result_in[1:0] == 2'b00);
    assign access        = mem_op & aligned;
    assign misaligned_op = mem_op & ~aligned;
    assign timeout_hit   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        err_d   = err_q;
        stall_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = MemWrite_in & ~MemRead_in;
                    addr_d  = alu_result_in;
                    wdata_d = write_data_in;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    rdata_d = 32'h0;
                end else if (misaligned_op) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    abort_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // What MEM/WB captures when not stalled: completed accesses use the
    // latched read data; misaligned or aborted accesses never write back.
    logic        wb_regwrite;
    logic [31:0] wb_read_data;

    always_comb begin
        wb_regwrite  = RegWrite_in;
        wb_read_data = 32'h0;
        if (state_q == DONE) begin
            wb_regwrite = RegWrite_in & ~abort_q;
            if (MemRead_in) begin
                wb_read_data = rdata_q;
            end
        end else if (misaligned_op) begin
            wb_regwrite = 1'b0;
        end
    end

    mem_wb_buffer u_mem_wb (
        .clk          (clk),
        .reset        (reset),
        .bubble_i     (stall_c),
        .regwrite_i   (wb_regwrite),
        .memtoreg_i   (MemtoReg_in),
        .read_data_i  (wb_read_data),
        .alu_result_i (alu_result_in),
        .write_reg_i  (write_reg_in),
        .regwrite_o   (RegWrite_out),
        .memtoreg_o   (MemtoReg_out),
        .read_data_o  (read_data_out),
        .alu_result_o (alu_result_out),
        .write_reg_o  (write_reg_out)
    );

    assign stall       = stall_c & ~reset;
    assign PCSrc       = Branch_in & Zero_in;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_error   = err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: randomized instruction stream against a
// behavioural model, with a queue-based scoreboard for MEM/WB captures.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int T = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        RegWrite_in = 0, MemtoReg_in = 0, MemRead_in = 0, MemWrite_in = 0;
    logic        Branch_in = 0, Zero_in = 0;
    logic [31:0] alu_result_in = 0, write_data_in = 0;
    logic [4:0]  write_reg_in = 0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic        mem_ready = 0;
    logic        stall, PCSrc, mem_error;
    logic        RegWrite_out, MemtoReg_out;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  write_reg_out;
    state_t      state_dbg;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .Branch_in(Branch_in), .Zero_in(Zero_in),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .write_reg_in(write_reg_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .PCSrc(PCSrc), .mem_error(mem_error),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .write_reg_out(write_reg_out), .state_dbg_o(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    // entry: {err, regwrite, memtoreg, read_data[31:0], alu_result[31:0], write_reg[4:0]}
    logic [71:0] exp_q[$];
    int total = 0;
    int bad = 0;
    bit mon_en = 0;
    bit err_exp = 0;
    int          cur_delay = 0;
    logic [31:0] cur_rdata = 0, cur_addr = 0, cur_wdata = 0;
    bit          cur_we = 0, cur_access = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int req_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            req_cnt = 0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (mon_en) begin
                check("bus_access_expected", 72'(cur_access), 72'(1));
                check("bus_addr", 72'(mem_addr), 72'(cur_addr));
                check("bus_we", 72'(mem_we), 72'(cur_we));
                if (cur_we) check("bus_wdata", 72'(mem_wdata), 72'(cur_wdata));
            end
            if (req_cnt == cur_delay) begin
                mem_ready = 1'b1;
                mem_rdata = cur_rdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            req_cnt++;
        end else begin
            if (req_cnt > 0 && mon_en)
                check("req_len", 72'(req_cnt), 72'((cur_delay < T) ? cur_delay + 1 : T));
            req_cnt = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // ---------------- monitor ----------------
    logic [71:0] last_e = 0, mon_e, mon_act;
    bit have_last = 0;
    bit mon_s, mon_go;
    always begin
        @(negedge clk);
        mon_s = stall;
        mon_go = mon_en;
        @(posedge clk);
        #1;
        if (mon_go && !reset) begin
            mon_act = {mem_error, RegWrite_out, MemtoReg_out, read_data_out, alu_result_out, write_reg_out};
            if (!mon_s) begin
                if (exp_q.size() == 0) begin
                    check("mem_wb_unexpected", mon_act, 72'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mem_wb", mon_act, mon_e);
                    last_e = mon_e;
                    have_last = 1;
                end
            end else if (have_last) begin
                check("bubble", {1'b0, mon_act[70:0]}, {3'b000, last_e[68:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_nop;
        RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        Branch_in = 0; Zero_in = 0; alu_result_in = 0; write_data_in = 0; write_reg_in = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 72'(mem_req), 72'(0));
        check({tag, "_stall"}, 72'(stall), 72'(0));
        check({tag, "_state"}, 72'(state_dbg), 72'(IDLE));
        check({tag, "_bus"}, 72'({mem_we, mem_addr, mem_wdata}), 72'(0));
        check({tag, "_err"}, 72'(mem_error), 72'(0));
        check({tag, "_wb"}, {RegWrite_out, MemtoReg_out, read_data_out, alu_result_out, write_reg_out}, 72'(0));
    endtask

    task automatic do_reset;
        mon_en = 0;
        drive_nop();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        err_exp = 0;
        have_last = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        mon_en = 1;
    endtask

    task automatic issue(input bit rw, input bit m2r, input bit mr, input bit mw,
                         input bit br, input bit z, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] wreg,
                         input int delay, input logic [31:0] rdata);
        bit memop, al, acc, tmo, exp_rw, s, done;
        logic [31:0] exp_rd;
        int exp_stall, stalls;
        memop = mr | mw;
        al = (addr[1:0] == 2'b00);
        acc = memop & al;
        tmo = acc && (delay >= T);
        exp_rw = rw;
        exp_rd = 32'h0;
        if (memop && !al) begin
            exp_rw = 0;
            err_exp = 1;
        end
        if (acc) begin
            if (tmo) begin
                exp_rw = 0;
                err_exp = 1;
            end else if (mr) begin
                exp_rd = rdata;
            end
        end
        exp_stall = !acc ? 0 : (tmo ? T + 1 : delay + 2);

        RegWrite_in = rw; MemtoReg_in = m2r; MemRead_in = mr; MemWrite_in = mw;
        Branch_in = br; Zero_in = z; alu_result_in = addr; write_data_in = wdata;
        write_reg_in = wreg;
        cur_delay = delay; cur_rdata = rdata; cur_addr = addr; cur_wdata = wdata;
        cur_we = mw & ~mr; cur_access = acc;
        exp_q.push_back({err_exp, exp_rw, m2r, exp_rd, addr, wreg});

        stalls = 0;
        done = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) check("pcsrc", 72'(PCSrc), 72'(br & z));
            s = stall;
            @(posedge clk);
            #1;
            if (!s) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) check("issue_timeout", 72'(0), 72'(1));
        check("stall_cycles", 72'(stalls), 72'(exp_stall));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int kind, dly;
        drive_nop();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a hung load: everything clears at once.
        @(posedge clk);
        #1;
        RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; alu_result_in = 32'h40; write_reg_in = 5'd7;
        cur_delay = 1000;
        repeat (3) @(posedge clk);
        #1 check("mid_access_req", 72'(mem_req), 72'(1));
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_access");
        drive_nop();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1;

        // Directed: nop, load, slow store, read+write, branches, timeout.
        issue(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 5'd3, 0, 32'h0);
        issue(1, 1, 1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 0, 32'hDEADBEEF);
        issue(0, 0, 0, 1, 0, 0, 32'h20, 32'h1234, 5'd0, 3, 32'h0);
        issue(1, 1, 1, 1, 0, 0, 32'h24, 32'h5555, 5'd9, 1, 32'hCAFE0001);
        issue(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        issue(0, 0, 0, 0, 1, 0, 32'h4, 32'h0, 5'd0, 0, 32'h0);
        issue(1, 1, 1, 0, 0, 0, 32'h30, 32'h0, 5'd6, 100, 32'h11111111);
        issue(1, 1, 1, 0, 0, 0, 32'h34, 32'h0, 5'd8, T - 1, 32'h22222222);
        issue(1, 0, 0, 0, 0, 0, 32'h200, 32'h0, 5'd4, 0, 32'h0);
        #2 mon_en = 0;
        check("queue_empty_a", 72'(exp_q.size()), 72'(0));

        // Misaligned access from a clean error state, then a random stream.
        do_reset();
        issue(1, 1, 1, 0, 0, 0, 32'h13, 32'h0, 5'd2, 0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            a = $urandom;
            a[1:0] = 2'b00;
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 3);
            case (kind)
                0: issue(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, $urandom, 0, 5'($urandom), 0, 0);
                1: issue(1'($urandom_range(0, 1)), 1, 1, 0, 0, 0, a, 0, 5'($urandom), dly, $urandom);
                2: issue(0, 0, 0, 1, 0, 0, a, $urandom, 5'($urandom), dly, $urandom);
                3: issue(1, 1, 1, 1, 0, 0, a, $urandom, 5'($urandom), dly, $urandom);
                4: issue(1, 1, 1'($urandom_range(0, 1)), 1, 0, 0, a | 32'($urandom_range(1, 3)),
                         $urandom, 5'($urandom), 0, 0);
                default: issue(0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), $urandom, 0, 5'($urandom), 0, 0);
            endcase
        end
        #2 mon_en = 0;
        check("queue_empty_b", 72'(exp_q.size()), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the 5-stage pipeline: consumes the EX/MEM register outputs, drives the data-memory bus with a req/ready handshake, resolves branches, and loads the MEM/WB register. It asserts `stall` toward the hazard unit while a load or store is in flight, so that IF/ID/EX/MEM hold their contents.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in ACCESS waiting for `mem_ready` before the access is aborted.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control bits from EX/MEM
- Zero_in  in  1  ALU zero flag from EX/MEM
- alu_result_in  in  32  address, or ALU result passed through
- write_data_in  in  32  store data
- write_reg_in  in  5  destination register
- mem_req  out  1  registered request to data memory
- mem_we  out  1  registered; 1 = write, 0 = read
- mem_addr, mem_wdata  out  32 each  registered, stable while `mem_req`=1
- mem_rdata  in  32  read data, valid in the cycle `mem_ready`=1
- mem_ready  in  1  completion strobe from memory
- stall  out  1  combinational; freeze upstream stages
- PCSrc  out  1  combinational `Branch_in & Zero_in`
- mem_error  out  1  sticky error flag, registered
- RegWrite_out, MemtoReg_out  out  1 each  MEM/WB control
- read_data_out, alu_result_out  out  32 each  MEM/WB data
- write_reg_out  out  5  MEM/WB destination register

## Operation
- Three-state FSM: IDLE, ACCESS, DONE.
- access = (MemRead_in | MemWrite_in) & aligned, where aligned = (alu_result_in[1:0] == 0).
- If both MemRead_in and MemWrite_in are set, the access is a read and the write is suppressed.
- IDLE:
  - If access: stall=1. At the next edge latch mem_addr, mem_wdata and mem_we, set mem_req=1, clear the counter, and go to ACCESS.
  - If misaligned and (MemRead_in | MemWrite_in): no bus activity, mem_error<=1, and the instruction enters MEM/WB with RegWrite_out=0.
- ACCESS:
  - stall=1; counter increments every cycle.
  - Edge with mem_ready=1: latch mem_rdata, mem_req<=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: mem_req<=0, mem_error<=1, latched read data = 0, abort flag set, go to DONE.
- DONE:
  - stall=0. At this edge MEM/WB captures the instruction, using the latched read data. RegWrite_out is forced to 0 if the abort flag is set.
  - Then go to IDLE unconditionally. EX/MEM advances on the same edge, so the instruction is never re-issued.
- MEM/WB register:
  - Captures on every edge where stall=0.
  - When stall=1 it loads a bubble: RegWrite_out=0, MemtoReg_out=0, other fields unchanged.
  - read_data_out is 0 for non-load instructions.
- mem_error is cleared only by reset.

## Timing
- Reset (asynchronous): state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_error=0, and all MEM/WB outputs = 0. A reset during ACCESS drops mem_req immediately.
- Non-memory instruction: 1-cycle latency into MEM/WB, no stall.
- Load/store with mem_ready in the first ACCESS cycle: 3 cycles (IDLE, ACCESS, DONE), stall high for 2 cycles.
- Each extra cycle that mem_ready stays low adds one stall cycle.
- mem_ready sampled in IDLE or DONE is ignored.
- Timeout: exactly TIMEOUT_CYCLES cycles in ACCESS before DONE.
- PCSrc has no stall gating; a branch never coincides with an access.

## Structure
- Package `mem_stage_pkg`: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the TIMEOUT_CYCLES default.
- Sub-module `mem_wb_buffer`: the MEM/WB register, with bubble input and asynchronous reset.
- The FSM, counter, bus registers and error flag live in the top module.

## Test plan
- Reset mid-ACCESS (mem_req=1) -> mem_req=0 and stall=0 asynchronously; all outputs 0; state IDLE.
- Load from alu_result_in=0x10, mem_ready high one cycle after mem_req, mem_rdata=0xDEADBEEF -> stall high for 2 cycles; read_data_out=0xDEADBEEF and RegWrite_out=1 on the 3rd edge.
- Store to 0x20 with write_data_in=0x1234, mem_ready delayed 4 cycles -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 held stable; stall high for 5 cycles; MEM/WB bubbles during the stall.
- No ready with TIMEOUT_CYCLES=8 -> mem_req drops after 8 ACCESS cycles; mem_error=1 (sticky); aborted load has RegWrite_out=0.
- Misaligned load at 0x13 -> no mem_req, no stall, mem_error=1, RegWrite_out=0.
- Branch_in=1 with Zero_in=1, then Zero_in=0 -> PCSrc=1, then 0, in the same cycle; no stall.
